// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the control unit: instruction
// geometry, opcode field position, bubble word and opcode encodings.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int OPC_W   = OPC_HI - OPC_LO + 1;

  // Bubble word; decodes as an R-type writing r0, which is harmless.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Opcode encodings shared with the control unit.
  typedef enum logic [OPC_W-1:0] {
    OP_RTYPE = 3'b000,
    OP_ADDI  = 3'b001,
    OP_LW    = 3'b100,
    OP_SW    = 3'b101,
    OP_BEQ   = 3'b110,
    OP_JMP   = 3'b111
  } opcode_e;

endpackage

// File: rtl/fetch_stage_instr_rom.sv
// Instruction ROM with an asynchronous (combinational) read port, so the
// only fetch latency comes from the IF/ID register downstream.
module instr_rom #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 16,
  parameter     INIT_FILE = "instr.hex"
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // Combinational read of the word at the current fetch address.
  assign data = mem[addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and a saturating count of instructions delivered to decode.
module fetch_stage #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = fetch_stage_pkg::INSTR_W,
  parameter     INIT_FILE = "instr.hex"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] IfId_Instr,
  output logic [ADDR_W-1:0]  IfId_PCNext,
  output logic               IfId_Valid,
  output logic [2:0]         OpCode,
  output logic [15:0]        FetchCount
);

  import fetch_stage_pkg::*;

  logic [INSTR_W-1:0] romData;
  logic [ADDR_W-1:0]  pcPlus1;

  // Count of delivered instructions, sticking at all-ones.
  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  instr_rom #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .addr(PC),
    .data(romData)
  );

  // Sequential PC wraps naturally at the address width.
  assign pcPlus1 = PC + ADDR_W'(1);

  // PC, IF/ID register and counter; priority rst > branch > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= '0;
      IfId_Instr  <= NOP_INSTR;
      IfId_PCNext <= '0;
      IfId_Valid  <= 1'b0;
      FetchCount  <= '0;
    end else if (BranchTaken) begin
      // Redirect and squash whatever was being fetched.
      PC          <= BranchTarget;
      IfId_Instr  <= NOP_INSTR;
      IfId_PCNext <= '0;
      IfId_Valid  <= 1'b0;
    end else if (!Stall) begin
      PC          <= pcPlus1;
      IfId_Instr  <= romData;
      IfId_PCNext <= pcPlus1;
      IfId_Valid  <= 1'b1;
      FetchCount  <= satInc(FetchCount);
    end
  end

  // Opcode is a register slice, so it only changes at clock edges.
  assign OpCode = IfId_Instr[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequence followed by a
// randomized run, all outputs compared against a behavioural model.
module tb_fetch_stage;

  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          Stall;
  logic          BranchTaken;
  logic [AW-1:0] BranchTarget;
  logic [AW-1:0] PC;
  logic [IW-1:0] IfId_Instr;
  logic [AW-1:0] IfId_PCNext;
  logic          IfId_Valid;
  logic [2:0]    OpCode;
  logic [15:0]   FetchCount;

  int passCnt  = 0;
  int totalCnt = 0;

  // Reference model state
  logic [IW-1:0] rom [DEPTH];
  int            mPC, mPCNext, mCount;
  logic [IW-1:0] mInstr;
  logic          mValid;

  fetch_stage #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .INIT_FILE("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .PC          (PC),
    .IfId_Instr  (IfId_Instr),
    .IfId_PCNext (IfId_PCNext),
    .IfId_Valid  (IfId_Valid),
    .OpCode      (OpCode),
    .FetchCount  (FetchCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Model of one clock edge, written from the stage's rules.
  task automatic modelEdge();
    if (rst) begin
      mPC = 0; mInstr = '0; mPCNext = 0; mValid = 1'b0; mCount = 0;
    end else if (BranchTaken) begin
      mPC = int'(BranchTarget); mInstr = '0; mPCNext = 0; mValid = 1'b0;
    end else if (!Stall) begin
      mInstr  = rom[mPC];
      mPCNext = (mPC + 1) % DEPTH;
      mPC     = mPCNext;
      mValid  = 1'b1;
      if (mCount < 65535) mCount = mCount + 1;
    end
  endtask

  task automatic chkAll(input string tag);
    chk({tag, ".PC"},     32'(PC),          32'(mPC));
    chk({tag, ".Instr"},  32'(IfId_Instr),  32'(mInstr));
    chk({tag, ".PCNext"}, 32'(IfId_PCNext), 32'(mPCNext));
    chk({tag, ".Valid"},  32'(IfId_Valid),  32'(mValid));
    chk({tag, ".OpCode"}, 32'(OpCode),      32'(mInstr[15:13]));
    chk({tag, ".Count"},  32'(FetchCount),  32'(mCount));
  endtask

  // One clock edge with the currently driven inputs, then full compare.
  task automatic step(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    chkAll(tag);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
    rst = r; Stall = s; BranchTaken = b; BranchTarget = t;
  endtask

  initial begin
    // ROM image: directed words at 0..3, random elsewhere.
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
    rom[0] = 16'h0123; rom[1] = 16'h8456; rom[2] = 16'hA789; rom[3] = 16'hE000;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = rom[i];
    mPC = 0; mPCNext = 0; mCount = 0; mInstr = '0; mValid = 1'b0;

    // Reset for two cycles
    drive(1'b1, 1'b0, 1'b0, '0);
    step("rst0");
    step("rst1");
    chk("rst.PC_zero", 32'(PC), 32'd0);
    chk("rst.Valid_zero", 32'(IfId_Valid), 32'd0);
    chk("rst.Count_zero", 32'(FetchCount), 32'd0);

    // Run
    drive(1'b0, 1'b0, 1'b0, '0);
    step("run1");
    chk("run1.Instr", 32'(IfId_Instr), 32'h0123);
    chk("run1.OpCode", 32'(OpCode), 32'd0);
    chk("run1.Valid", 32'(IfId_Valid), 32'd1);
    chk("run1.PC", 32'(PC), 32'd1);
    step("run2");
    chk("run2.Instr", 32'(IfId_Instr), 32'h8456);
    chk("run2.OpCode", 32'(OpCode), 32'd4);
    chk("run2.PC", 32'(PC), 32'd2);

    // Stall two cycles
    drive(1'b0, 1'b1, 1'b0, '0);
    step("stall1");
    step("stall2");
    chk("stall.Instr", 32'(IfId_Instr), 32'h8456);
    chk("stall.PC", 32'(PC), 32'd2);
    chk("stall.Count", 32'(FetchCount), 32'd2);
    drive(1'b0, 1'b0, 1'b0, '0);
    step("release");
    chk("release.Instr", 32'(IfId_Instr), 32'hA789);
    chk("release.OpCode", 32'(OpCode), 32'd5);
    chk("release.PC", 32'(PC), 32'd3);
    chk("release.Count", 32'(FetchCount), 32'd3);

    // Branch flush to 0
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    step("flush");
    chk("flush.PC", 32'(PC), 32'd0);
    chk("flush.Instr", 32'(IfId_Instr), 32'd0);
    chk("flush.Valid", 32'(IfId_Valid), 32'd0);
    chk("flush.Count", 32'(FetchCount), 32'd3);
    drive(1'b0, 1'b0, 1'b0, '0);
    step("postflush");
    chk("postflush.Instr", 32'(IfId_Instr), 32'h0123);
    chk("postflush.Valid", 32'(IfId_Valid), 32'd1);

    // Branch and stall together: branch wins
    drive(1'b0, 1'b1, 1'b1, 8'h02);
    step("brstall");
    chk("brstall.PC", 32'(PC), 32'd2);
    chk("brstall.Valid", 32'(IfId_Valid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h02);
    step("brstall_hold");
    chk("brstall_hold.PC", 32'(PC), 32'd2);
    chk("brstall_hold.Valid", 32'(IfId_Valid), 32'd0);

    // Wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    step("wrap_redirect");
    drive(1'b0, 1'b0, 1'b0, '0);
    step("wrap1");
    chk("wrap1.Instr", 32'(IfId_Instr), 32'(rom[255]));
    chk("wrap1.PCNext", 32'(IfId_PCNext), 32'd0);
    chk("wrap1.PC", 32'(PC), 32'd0);
    step("wrap2");
    chk("wrap2.Instr", 32'(IfId_Instr), 32'h0123);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), AW'($urandom));
      step("rand");
    end

    // Establish some state, then reset together with a branch
    drive(1'b0, 1'b0, 1'b0, '0);
    step("pre_rst");
    drive(1'b1, 1'b1, 1'b1, 8'h10);
    step("midrst");
    chk("midrst.PC", 32'(PC), 32'd0);
    chk("midrst.Instr", 32'(IfId_Instr), 32'd0);
    chk("midrst.Valid", 32'(IfId_Valid), 32'd0);
    chk("midrst.Count", 32'(FetchCount), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
